// File: rtl/control_pkg.sv
// control_pkg: shared types and encodings for the multi-cycle controller.
//   state_t        controller states (JMP exists only with CONTROL_JUMP_EN)
//   instr_class_t  instruction classes produced by instr_decode
//   ctrl_t         bundle of every registered datapath control output
//   OP_*/EXT_*     opcode and extension field values
//   ALU_*          alucont codes; WD_*/ALUA_*/ALUB_*/PC_*/MEM_* select codes
// Optional feature macro: CONTROL_JUMP_EN (enables JAL/JUMP and the JMP state).
package control_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DECODE,
    ST_EX_ALU,
    ST_EX_MOV,
    ST_LD_ADDR,
    ST_LD_WB,
    ST_ST,
    ST_HALT
`ifdef CONTROL_JUMP_EN
    , ST_JMP
`endif
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_ALUI,
    CL_MOV,
    CL_MOVI,
    CL_LOAD,
    CL_STOR,
    CL_JAL,
    CL_JUMP,
    CL_HALT,
    CL_ILLEGAL
  } instr_class_t;

  // Opcode field [15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  // Extension field [7:4], R-type
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  // Extension field [7:4], memory/jump group
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JAL  = 4'b1000;
  localparam logic [3:0] EXT_JUMP = 4'b1100;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;

  // Datapath select codes
  localparam logic [1:0] WD_IMM    = 2'd0;
  localparam logic [1:0] WD_RSRC   = 2'd1;
  localparam logic [1:0] WD_MEM    = 2'd2;
  localparam logic [1:0] WD_ALU    = 2'd3;
  localparam logic [1:0] ALUA_RSRC = 2'd0;
  localparam logic [1:0] ALUA_PC   = 2'd1;
  localparam logic [1:0] ALUA_IMM  = 2'd2;
  localparam logic       ALUB_RDEST = 1'b0;
  localparam logic       ALUB_ONE   = 1'b1;
  localparam logic       PC_RSRC    = 1'b0;
  localparam logic       PC_ALU     = 1'b1;
  localparam logic       MEM_RSRC   = 1'b0;
  localparam logic       MEM_PC     = 1'b1;

  typedef struct packed {
    logic       pcen;
    logic       regwrite;
    logic       mem_we;
    logic       signext_sign;
    logic       wa_s;
    logic       pc_s;
    logic       alub_s;
    logic       mem_s;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [2:0] alucont;
    logic       busy;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational classification of an instruction word.
// Ports:
//   ir            in  INSTR_W  instruction word
//   cls           out          instruction class
//   alucont       out  3       ALU operation for the execute step
//   signext_sign  out  1       1 = sign-extend immediate, 0 = zero-extend
//   illegal       out  1       word does not decode to a supported instruction
// Optional feature macro: CONTROL_JUMP_EN (JAL/JUMP decode as legal).
module instr_decode
  import control_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output instr_class_t       cls,
  output logic [2:0]         alucont,
  output logic               signext_sign,
  output logic               illegal
);

  logic [3:0] op;
  logic [3:0] ext;

  assign op  = ir[15:12];
  assign ext = ir[7:4];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cls          = CL_ILLEGAL;
    alucont      = ALU_ADD;
    signext_sign = 1'b0;

    if (ir == HALT_WORD) begin
      cls = CL_HALT;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (ext)
            EXT_ADD: begin cls = CL_ALU; alucont = ALU_ADD;   end
            EXT_SUB: begin cls = CL_ALU; alucont = ALU_SUB;   end
            EXT_AND: begin cls = CL_ALU; alucont = ALU_AND;   end
            EXT_OR:  begin cls = CL_ALU; alucont = ALU_OR;    end
            EXT_XOR: begin cls = CL_ALU; alucont = ALU_XOR;   end
            EXT_MOV: begin cls = CL_MOV; alucont = ALU_PASSA; end
            default: cls = CL_ILLEGAL;
          endcase
        end
        OP_ADDI: begin
          cls          = CL_ALUI;
          alucont      = ALU_ADD;
          signext_sign = 1'b1;
        end
        OP_SUBI: begin
          cls          = CL_ALUI;
          alucont      = ALU_SUB;
          signext_sign = 1'b1;
        end
        OP_MOVI: cls = CL_MOVI;
        OP_MEM: begin
          case (ext)
            EXT_LOAD: cls = CL_LOAD;
            EXT_STOR: cls = CL_STOR;
`ifdef CONTROL_JUMP_EN
            EXT_JAL:  begin cls = CL_JAL; alucont = ALU_PASSA; end
            EXT_JUMP: cls = CL_JUMP;
`endif
            default:  cls = CL_ILLEGAL;
          endcase
        end
        default: cls = CL_ILLEGAL;
      endcase
    end

    illegal = (cls == CL_ILLEGAL);
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle controller for the 16-bit datapath. Holds the
// instruction register and sequences FETCH -> LATCH -> DECODE -> execute.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   run                        start/continue, sampled at instruction boundaries
//   mem_out [WIDTH]            synchronous-read memory data
//   pcen, regwrite, mem_we     PC enable, register write, memory write strobes
//   signext_sign               1 = sign-extend immediate
//   wa_s, pc_s, alub_s, mem_s  2:1 datapath selects
//   wd_s, alua_s               4:1 datapath selects
//   alucont [3]                ALU operation
//   imm, rsrc_addr, rdest_addr instruction fields straight from ir
//   busy, halted, illegal      status; illegal is a one-cycle pulse
// Optional feature macro: CONTROL_JUMP_EN (JAL/JUMP via the JMP state).
module control_fsm
  import control_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REG_ADD = 4,
  parameter int IMM     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [WIDTH-1:0]   mem_out,
  output logic               pcen,
  output logic               regwrite,
  output logic               mem_we,
  output logic               signext_sign,
  output logic               wa_s,
  output logic               pc_s,
  output logic               alub_s,
  output logic               mem_s,
  output logic [1:0]         wd_s,
  output logic [1:0]         alua_s,
  output logic [2:0]         alucont,
  output logic [IMM-1:0]     imm,
  output logic [REG_ADD-1:0] rsrc_addr,
  output logic [REG_ADD-1:0] rdest_addr,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] ir_nxt;
  ctrl_t            ctrl_q;

  instr_class_t     dec_cls;
  logic [2:0]       dec_alucont;
  logic             dec_sext;
  logic             dec_illegal;

  // Decode the word that ir will hold after this edge, so that outputs for
  // DECODE and the execute states can be registered ahead of time.
  assign ir_nxt = (state == ST_LATCH) ? mem_out : ir;

  instr_decode u_decode (
    .ir           (ir_nxt),
    .cls          (dec_cls),
    .alucont      (dec_alucont),
    .signext_sign (dec_sext),
    .illegal      (dec_illegal)
  );

  function automatic state_t next_state(input state_t s, input logic go,
                                        input instr_class_t c);
    state_t boundary;
    boundary = go ? ST_FETCH : ST_IDLE;
    case (s)
      ST_IDLE:    next_state = go ? ST_FETCH : ST_IDLE;
      ST_FETCH:   next_state = ST_LATCH;
      ST_LATCH:   next_state = ST_DECODE;
      ST_DECODE: begin
        case (c)
          CL_ALU, CL_ALUI: next_state = ST_EX_ALU;
          CL_MOV, CL_MOVI: next_state = ST_EX_MOV;
          CL_LOAD:         next_state = ST_LD_ADDR;
          CL_STOR:         next_state = ST_ST;
`ifdef CONTROL_JUMP_EN
          CL_JAL, CL_JUMP: next_state = ST_JMP;
`endif
          CL_HALT:         next_state = ST_HALT;
          default:         next_state = boundary;  // illegal ends here
        endcase
      end
      ST_LD_ADDR: next_state = ST_LD_WB;
      ST_HALT:    next_state = ST_HALT;
      default:    next_state = boundary;  // last cycle of an instruction
    endcase
  endfunction

  // Moore outputs for state s with the instruction that will be in ir.
  function automatic ctrl_t ctrl_for(input state_t s, input instr_class_t c,
                                     input logic [2:0] alu, input logic sext,
                                     input logic ill);
    ctrl_t k;
    k        = '0;
    k.busy   = (s != ST_IDLE) && (s != ST_HALT);
    k.halted = (s == ST_HALT);
    case (s)
      ST_FETCH: k.mem_s = MEM_PC;
      ST_LATCH: begin
        k.pcen    = 1'b1;
        k.pc_s    = PC_ALU;
        k.alua_s  = ALUA_PC;
        k.alub_s  = ALUB_ONE;
        k.alucont = ALU_ADD;
      end
      ST_DECODE: k.illegal = ill;
      ST_EX_ALU: begin
        k.regwrite     = 1'b1;
        k.wd_s         = WD_ALU;
        k.wa_s         = 1'b1;
        k.alucont      = alu;
        k.alua_s       = (c == CL_ALUI) ? ALUA_IMM : ALUA_RSRC;
        k.alub_s       = ALUB_RDEST;
        k.signext_sign = sext;
      end
      ST_EX_MOV: begin
        k.regwrite = 1'b1;
        k.wa_s     = 1'b1;
        k.wd_s     = (c == CL_MOV) ? WD_RSRC : WD_IMM;
      end
      ST_LD_ADDR: k.mem_s = MEM_RSRC;
      ST_LD_WB: begin
        k.regwrite = 1'b1;
        k.wa_s     = 1'b1;
        k.wd_s     = WD_MEM;
      end
      ST_ST: begin
        k.mem_s  = MEM_RSRC;
        k.mem_we = 1'b1;
      end
`ifdef CONTROL_JUMP_EN
      ST_JMP: begin
        k.pcen = 1'b1;
        k.pc_s = PC_RSRC;
        if (c == CL_JAL) begin
          // pc already holds the incremented value from LATCH
          k.regwrite = 1'b1;
          k.wa_s     = 1'b1;
          k.wd_s     = WD_ALU;
          k.alua_s   = ALUA_PC;
          k.alucont  = ALU_PASSA;
        end
      end
`endif
      default: ;
    endcase
    ctrl_for = k;
  endfunction

  assign state_nxt = next_state(state, run, dec_cls);

  // NOTE: state, ir and the output register all use non-blocking assignment
  // and are all cleared by reset, so no strobe can survive a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ir     <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      ctrl_q <= ctrl_for(state_nxt, dec_cls, dec_alucont, dec_sext, dec_illegal);
    end
  end

  assign pcen         = ctrl_q.pcen;
  assign regwrite     = ctrl_q.regwrite;
  assign mem_we       = ctrl_q.mem_we;
  assign signext_sign = ctrl_q.signext_sign;
  assign wa_s         = ctrl_q.wa_s;
  assign pc_s         = ctrl_q.pc_s;
  assign alub_s       = ctrl_q.alub_s;
  assign mem_s        = ctrl_q.mem_s;
  assign wd_s         = ctrl_q.wd_s;
  assign alua_s       = ctrl_q.alua_s;
  assign alucont      = ctrl_q.alucont;
  assign busy         = ctrl_q.busy;
  assign halted       = ctrl_q.halted;
  assign illegal      = ctrl_q.illegal;

  assign imm        = ir[IMM-1:0];
  assign rsrc_addr  = ir[REG_ADD-1:0];
  assign rdest_addr = ir[8 +: REG_ADD];

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed stimulus with a scoreboard. The stimulus process
// pushes the expected outputs for the coming clock edge; the monitor pops and
// compares one entry per cycle shortly after each rising edge.
module tb_control_fsm;

  typedef struct packed {
    logic       pcen;
    logic       regwrite;
    logic       mem_we;
    logic       signext_sign;
    logic       wa_s;
    logic       pc_s;
    logic       alub_s;
    logic       mem_s;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [2:0] alucont;
    logic       busy;
    logic       halted;
    logic       illegal;
  } exp_t;

  typedef struct {
    string      nm;
    exp_t       c;
    bit         chk;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [7:0] im;
  } sb_t;

  localparam exp_t E_IDLE  = '{default: '0};
  localparam exp_t E_FETCH = '{mem_s: 1'b1, busy: 1'b1, default: '0};
  localparam exp_t E_LATCH = '{pcen: 1'b1, pc_s: 1'b1, alua_s: 2'd1, alub_s: 1'b1,
                               busy: 1'b1, default: '0};
  localparam exp_t E_DEC   = '{busy: 1'b1, default: '0};
  localparam exp_t E_ILL   = '{illegal: 1'b1, busy: 1'b1, default: '0};
  localparam exp_t E_HALT  = '{halted: 1'b1, default: '0};

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] mem_out;
  logic        pcen, regwrite, mem_we, signext_sign;
  logic        wa_s, pc_s, alub_s, mem_s;
  logic [1:0]  wd_s, alua_s;
  logic [2:0]  alucont;
  logic [7:0]  imm;
  logic [3:0]  rsrc_addr, rdest_addr;
  logic        busy, halted, illegal;

  int  total = 0;
  int  bad   = 0;
  sb_t q[$];

  always #5 clk = ~clk;

  control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .mem_out      (mem_out),
    .pcen         (pcen),
    .regwrite     (regwrite),
    .mem_we       (mem_we),
    .signext_sign (signext_sign),
    .wa_s         (wa_s),
    .pc_s         (pc_s),
    .alub_s       (alub_s),
    .mem_s        (mem_s),
    .wd_s         (wd_s),
    .alua_s       (alua_s),
    .alucont      (alucont),
    .imm          (imm),
    .rsrc_addr    (rsrc_addr),
    .rdest_addr   (rdest_addr),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled 1 time unit after the edge.
  initial begin
    sb_t  s;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        s = q.pop_front();
        a = '{pcen: pcen, regwrite: regwrite, mem_we: mem_we,
              signext_sign: signext_sign, wa_s: wa_s, pc_s: pc_s,
              alub_s: alub_s, mem_s: mem_s, wd_s: wd_s, alua_s: alua_s,
              alucont: alucont, busy: busy, halted: halted, illegal: illegal};
        check(s.nm, 32'(a), 32'(s.c));
        if (s.chk)
          check({s.nm, "/fields"}, {16'h0, rdest_addr, rsrc_addr, imm},
                {16'h0, s.rd, s.rs, s.im});
      end
    end
  end

  task automatic step(input string nm, input exp_t e, input bit chk = 1'b0,
                      input logic [3:0] rd = 4'h0, input logic [3:0] rs = 4'h0,
                      input logic [7:0] im = 8'h00);
    sb_t s;
    s.nm = nm; s.c = e; s.chk = chk; s.rd = rd; s.rs = rs; s.im = im;
    q.push_back(s);
    @(negedge clk);
  endtask

  task automatic fetch3(input logic [15:0] w, input string nm, input exp_t dec);
    mem_out = w;
    step({nm, "/fetch"},  E_FETCH);
    step({nm, "/latch"},  E_LATCH);
    step({nm, "/decode"}, dec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    run     = 1'b1;
    mem_out = 16'h0351;
    step("rst0", E_IDLE, 1'b1, 4'h0, 4'h0, 8'h00);
    step("rst1", E_IDLE, 1'b1, 4'h0, 4'h0, 8'h00);
    reset = 1'b0;

    fetch3(16'h0351, "add", E_DEC);
    step("add/ex", '{regwrite: 1'b1, wd_s: 2'd3, wa_s: 1'b1, alucont: 3'b000,
                     busy: 1'b1, default: '0}, 1'b1, 4'h3, 4'h1, 8'h51);

    fetch3(16'h0391, "sub", E_DEC);
    step("sub/ex", '{regwrite: 1'b1, wd_s: 2'd3, wa_s: 1'b1, alucont: 3'b001,
                     busy: 1'b1, default: '0}, 1'b1, 4'h3, 4'h1, 8'h91);

    fetch3(16'h0532, "xor", E_DEC);
    step("xor/ex", '{regwrite: 1'b1, wd_s: 2'd3, wa_s: 1'b1, alucont: 3'b100,
                     busy: 1'b1, default: '0}, 1'b1, 4'h5, 4'h2, 8'h32);

    fetch3(16'h52FF, "addi", E_DEC);
    step("addi/ex", '{regwrite: 1'b1, wd_s: 2'd3, wa_s: 1'b1, alua_s: 2'd2,
                      signext_sign: 1'b1, alucont: 3'b000, busy: 1'b1,
                      default: '0}, 1'b1, 4'h2, 4'hF, 8'hFF);

    fetch3(16'hD2FF, "movi", E_DEC);
    step("movi/ex", '{regwrite: 1'b1, wa_s: 1'b1, wd_s: 2'd0, busy: 1'b1,
                      default: '0}, 1'b1, 4'h2, 4'hF, 8'hFF);

    fetch3(16'h01D2, "mov", E_DEC);
    step("mov/ex", '{regwrite: 1'b1, wa_s: 1'b1, wd_s: 2'd1, busy: 1'b1,
                     default: '0}, 1'b1, 4'h1, 4'h2, 8'hD2);

    fetch3(16'h0071, "badext", E_ILL);

    fetch3(16'h4402, "load", E_DEC);
    step("load/addr", E_DEC, 1'b1, 4'h4, 4'h2, 8'h02);
    step("load/wb", '{regwrite: 1'b1, wd_s: 2'd2, wa_s: 1'b1, busy: 1'b1,
                      default: '0});

    fetch3(16'h4443, "stor", E_DEC);
    step("stor/st", '{mem_we: 1'b1, busy: 1'b1, default: '0}, 1'b1,
         4'h4, 4'h3, 8'h43);

`ifdef CONTROL_JUMP_EN
    fetch3(16'h4A83, "jal", E_DEC);
    step("jal/jmp", '{pcen: 1'b1, regwrite: 1'b1, pc_s: 1'b0, alua_s: 2'd1,
                      alucont: 3'b101, wd_s: 2'd3, wa_s: 1'b1, busy: 1'b1,
                      default: '0}, 1'b1, 4'hA, 4'h3, 8'h83);
    fetch3(16'h4AC3, "jump", E_DEC);
    step("jump/jmp", '{pcen: 1'b1, busy: 1'b1, default: '0});
`else
    fetch3(16'h4A83, "jal", E_ILL);
    fetch3(16'h4AC3, "jump", E_ILL);
`endif

    fetch3(16'h7000, "op7", E_ILL);

    // run drops while LD_ADDR is active: LD_WB still completes, then IDLE
    fetch3(16'h4402, "loadstop", E_DEC);
    step("loadstop/addr", E_DEC);
    run = 1'b0;
    step("loadstop/wb", '{regwrite: 1'b1, wd_s: 2'd2, wa_s: 1'b1, busy: 1'b1,
                          default: '0});
    step("loadstop/idle0", E_IDLE);
    step("loadstop/idle1", E_IDLE);
    run = 1'b1;

    fetch3(16'hFFFF, "halt", E_DEC);
    for (int i = 0; i < 20; i++) step($sformatf("halt/h%0d", i), E_HALT);

    reset = 1'b1;
    step("halt/reset", E_IDLE, 1'b1, 4'h0, 4'h0, 8'h00);
    reset = 1'b0;

    // reset arriving in DECODE must suppress the pending regwrite
    fetch3(16'h0351, "kill", E_DEC);
    reset = 1'b1;
    step("kill/reset", E_IDLE, 1'b1, 4'h0, 4'h0, 8'h00);
    reset = 1'b0;
    run   = 1'b0;
    step("kill/idle", E_IDLE);

    @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
